// File: rtl/sar_ctrl_pkg.sv
// sar_ctrl_pkg
//   Shared definitions for the SAR conversion sequencer:
//   - default parameter constants (code width, oversampling limit, period
//     width, timeout length)
//   - the sequencer state encoding, also exported on the debug state port
package sar_ctrl_pkg;

    localparam int RES_DEF          = 6;
    localparam int PERIOD_W_DEF     = 8;
    localparam int MAX_OSR_LOG2_DEF = 3;
    localparam int TIMEOUT_CYC_DEF  = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        WAIT  = 3'd2,
        ACC   = 3'd3,
        GAP   = 3'd4
    } sar_state_e;

endpackage

// File: rtl/sar_rate_timer.sv
// sar_rate_timer
//   Loadable down-counter that saturates at zero. "expired" is high
//   whenever the count is zero.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   clear       - force the count to zero (highest priority)
//   load        - load load_val
//   load_val    - value to load
//   expired     - count == 0
module sar_rate_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - ONE;
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/sar_conv_ctrl.sv
// sar_conv_ctrl
//   Conversion sequencer for the SAR ADC core. Launches single or
//   continuous bursts, spaces conversion starts by a programmable period,
//   times out a silent core, averages 2^osr codes per burst and offers the
//   average on a valid/ready result port.
// Ports:
//   clk, rst_n                - clock, asynchronous active-low reset
//   enable                    - low aborts everything and returns to IDLE
//   continuous, single_shot   - burst launch control
//   period                    - start-to-start spacing in cycles
//   osr_log2                  - averaging exponent, clamped to MAX_OSR_LOG2
//   adc_start/adc_done/adc_code - SAR core interface
//   result_data/valid/ready   - averaged result port
//   busy                      - sequencer not in IDLE
//   overrun, err_timeout      - sticky flags, cleared by clear_flags
//   state_dbg                 - current sequencer state (sar_state_e)
//
// Result handshake: result_valid rises with result_data loaded; both hold
// until a cycle where result_valid & result_ready, in which the consumer
// takes the data. A new result arriving while valid is held without ready
// is dropped (overrun); one arriving in a handshake cycle replaces the data
// and valid stays high.
module sar_conv_ctrl
    import sar_ctrl_pkg::*;
#(
    parameter int RES          = RES_DEF,
    parameter int PERIOD_W     = PERIOD_W_DEF,
    parameter int MAX_OSR_LOG2 = MAX_OSR_LOG2_DEF,
    parameter int TIMEOUT_CYC  = TIMEOUT_CYC_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                continuous,
    input  logic                single_shot,
    input  logic [PERIOD_W-1:0] period,
    input  logic [2:0]          osr_log2,
    output logic                adc_start,
    input  logic                adc_done,
    input  logic [RES-1:0]      adc_code,
    output logic [RES-1:0]      result_data,
    output logic                result_valid,
    input  logic                result_ready,
    output logic                busy,
    output logic                overrun,
    output logic                err_timeout,
    input  logic                clear_flags,
    output logic [2:0]          state_dbg
);

    localparam int ACC_W = RES + MAX_OSR_LOG2;
    localparam int CNT_W = (MAX_OSR_LOG2 > 0) ? MAX_OSR_LOG2 : 1;
    localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [TO_W-1:0]  TO_ONE  = TO_W'(1);
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [2:0]       OSR_MAX = 3'(MAX_OSR_LOG2);

    sar_state_e          state;
    logic [ACC_W-1:0]    acc;
    logic [CNT_W-1:0]    sample_cnt;
    logic [2:0]          osr_q;
    logic [RES-1:0]      code_q;
    logic [TO_W-1:0]     to_cnt;

    logic                timer_expired;
    logic [PERIOD_W-1:0] timer_load_val;
    logic [2:0]          osr_clamped;
    logic [CNT_W-1:0]    last_cnt;
    logic [ACC_W-1:0]    acc_sum;
    logic [RES-1:0]      result_next;

    // The timer is loaded at the end of START and must read zero in the
    // cycle before the next START, so it holds period-2. Periods 0 and 1
    // collapse to back-to-back operation, limited by the conversion itself.
    assign timer_load_val = (period < PERIOD_W'(2)) ? '0 : (period - PERIOD_W'(2));

    assign osr_clamped = (osr_log2 > OSR_MAX) ? OSR_MAX : osr_log2;
    assign last_cnt    = CNT_W'((32'd1 << osr_q) - 32'd1);
    assign acc_sum     = acc + {{MAX_OSR_LOG2{1'b0}}, code_q};
    assign result_next = RES'(acc_sum >> osr_q);

    sar_rate_timer #(
        .W (PERIOD_W)
    ) u_period_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (!enable),
        .load     (enable && (state == START)),
        .load_val (timer_load_val),
        .expired  (timer_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            adc_start    <= 1'b0;
            acc          <= '0;
            sample_cnt   <= '0;
            osr_q        <= '0;
            code_q       <= '0;
            to_cnt       <= '0;
            result_data  <= '0;
            result_valid <= 1'b0;
            overrun      <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            adc_start <= 1'b0;

            // Clears come first so a set event later in this block wins.
            if (clear_flags) begin
                overrun     <= 1'b0;
                err_timeout <= 1'b0;
            end

            if (result_valid && result_ready) begin
                result_valid <= 1'b0;
            end

            if (!enable) begin
                state      <= IDLE;
                acc        <= '0;
                sample_cnt <= '0;
                to_cnt     <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (continuous || single_shot) begin
                            state      <= START;
                            adc_start  <= 1'b1;
                            osr_q      <= osr_clamped;
                            acc        <= '0;
                            sample_cnt <= '0;
                        end
                    end

                    START: begin
                        to_cnt <= '0;
                        state  <= WAIT;
                    end

                    WAIT: begin
                        if (adc_done) begin
                            code_q <= adc_code;
                            state  <= ACC;
                        end else if (to_cnt == TO_LAST) begin
                            err_timeout <= 1'b1;
                            acc         <= '0;
                            sample_cnt  <= '0;
                            state       <= IDLE;
                        end else begin
                            to_cnt <= to_cnt + TO_ONE;
                        end
                    end

                    ACC: begin
                        if (sample_cnt == last_cnt) begin
                            if (result_valid && !result_ready) begin
                                overrun <= 1'b1;
                            end else begin
                                result_data  <= result_next;
                                result_valid <= 1'b1;
                            end
                            acc        <= '0;
                            sample_cnt <= '0;
                            if (continuous) begin
                                osr_q <= osr_clamped;
                                if (timer_expired) begin
                                    state     <= START;
                                    adc_start <= 1'b1;
                                end else begin
                                    state <= GAP;
                                end
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            acc        <= acc_sum;
                            sample_cnt <= sample_cnt + CNT_ONE;
                            if (timer_expired) begin
                                state     <= START;
                                adc_start <= 1'b1;
                            end else begin
                                state <= GAP;
                            end
                        end
                    end

                    GAP: begin
                        if (timer_expired) begin
                            state     <= START;
                            adc_start <= 1'b1;
                        end
                    end

                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign busy      = (state != IDLE);
    assign state_dbg = state;

endmodule
